// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment page scheduler.
// The state enum, page codes and the page-selection helpers are used by seg_page_sched.
package seg_pkg;

   localparam int DIGITS = 6;
   localparam int DATA_W = 4 * DIGITS;
   localparam int PAGE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PG_TIME = 2'd1,
      ST_PG_DATE = 2'd2,
      ST_OVL     = 2'd3
   } state_t;

   localparam logic [PAGE_W-1:0] PAGE_TIME = 2'd0;
   localparam logic [PAGE_W-1:0] PAGE_DATE = 2'd1;
   localparam logic [PAGE_W-1:0] PAGE_OVL  = 2'd2;
   localparam logic [PAGE_W-1:0] PAGE_IDLE = 2'd3;

   // Keep the current page if still enabled, else fall to the other one, else IDLE.
   function automatic state_t resolve_page(input state_t cur, input logic [1:0] en);
      state_t nxt;
      nxt = ST_IDLE;
      case (cur)
         ST_PG_TIME: nxt = en[0] ? ST_PG_TIME : (en[1] ? ST_PG_DATE : ST_IDLE);
         ST_PG_DATE: nxt = en[1] ? ST_PG_DATE : (en[0] ? ST_PG_TIME : ST_IDLE);
         default:    nxt = en[0] ? ST_PG_TIME : (en[1] ? ST_PG_DATE : ST_IDLE);
      endcase
      return nxt;
   endfunction

   function automatic state_t rotate_page(input state_t cur, input logic [1:0] en);
      state_t nxt;
      nxt = cur;
      case (cur)
         ST_PG_TIME: nxt = en[1] ? ST_PG_DATE : ST_PG_TIME;
         ST_PG_DATE: nxt = en[0] ? ST_PG_TIME : ST_PG_DATE;
         default:    nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/seg_ms_tick.sv
// Millisecond prescaler plus the edit-mode blink phase.
// The blink phase exists only when SEG_BLINK_EN is defined; otherwise blink_off is tied low.
module seg_ms_tick #(
   parameter int TICK_DIV = 50_000,
   parameter int BLINK_MS = 500
) (
   input  logic clk,
   input  logic rst,
   output logic tick_ms,
   output logic blink_off
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0] pre_q, pre_d;

   assign tick_ms = (pre_q == PRE_W'(TICK_DIV - 1));
   assign pre_d   = tick_ms ? '0 : pre_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

`ifdef SEG_BLINK_EN
   localparam int BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

   logic [BL_W-1:0] bl_q, bl_d;
   logic            phase_q, phase_d;

   always_comb begin
      bl_d    = bl_q;
      phase_d = phase_q;
      if (tick_ms) begin
         if (bl_q == BL_W'(BLINK_MS - 1)) begin
            bl_d    = '0;
            phase_d = ~phase_q;
         end else begin
            bl_d = bl_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bl_q    <= '0;
         phase_q <= 1'b0;
      end else begin
         bl_q    <= bl_d;
         phase_q <= phase_d;
      end
   end

   assign blink_off = phase_q;
`else
   assign blink_off = 1'b0;
`endif

endmodule

// File: rtl/seg_page_sched.sv
// Page scheduler for the 6-digit scan driver: rotates time/date pages and pre-empts them
// with a timed overlay. Blink masking of edit digits is enabled by defining SEG_BLINK_EN.
module seg_page_sched
   import seg_pkg::*;
#(
   parameter int TICK_DIV = 50_000,
   parameter int PAGE_MS  = 3000,
   parameter int OVL_MS   = 2000,
   parameter int BLINK_MS = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        page_en,
   input  logic [DATA_W-1:0] time_data,
   input  logic [DIGITS-1:0] time_point,
   input  logic [DATA_W-1:0] date_data,
   input  logic [DIGITS-1:0] date_point,
   input  logic              ovl_req,
   input  logic [DATA_W-1:0] ovl_data,
   input  logic [DIGITS-1:0] ovl_point,
   output logic              ovl_ack,
   input  logic [DIGITS-1:0] edit_mask,
   output logic [DATA_W-1:0] data,
   output logic [DIGITS-1:0] point,
   output logic [DIGITS-1:0] dig_blank,
   output logic [PAGE_W-1:0] page
);

   localparam int TMR_MAX = (PAGE_MS > OVL_MS) ? PAGE_MS : OVL_MS;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   logic tick_ms, blink_off;

   seg_ms_tick #(
      .TICK_DIV (TICK_DIV),
      .BLINK_MS (BLINK_MS)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .tick_ms   (tick_ms),
      .blink_off (blink_off)
   );

   state_t            state_q, state_d, ret_q, ret_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              tmr_term, accept;
   logic [DATA_W-1:0] ovl_data_q, data_q, data_d;
   logic [DIGITS-1:0] ovl_point_q, point_q, point_d, blank_q, blank_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic              ack_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ret_q       <= ST_IDLE;
         tmr_q       <= '0;
         ovl_data_q  <= '0;
         ovl_point_q <= '0;
         ack_q       <= 1'b0;
         data_q      <= '0;
         point_q     <= '0;
         blank_q     <= '1;
         page_q      <= PAGE_IDLE;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         tmr_q   <= tmr_d;
         ack_q   <= accept;
         if (accept) begin
            ovl_data_q  <= ovl_data;
            ovl_point_q <= ovl_point;
         end
         data_q  <= data_d;
         point_q <= point_d;
         blank_q <= blank_d;
         page_q  <= page_d;
      end
   end

   // One timer serves both page dwell and overlay hold; any state change or accept restarts it.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      accept   = ovl_req;
      tmr_term = tick_ms && (tmr_q == ((state_q == ST_OVL) ? TMR_W'(OVL_MS - 1)
                                                            : TMR_W'(PAGE_MS - 1)));
      if (accept) begin
         state_d = ST_OVL;
         if (state_q != ST_OVL) ret_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE: state_d = resolve_page(ST_IDLE, page_en);
            ST_PG_TIME, ST_PG_DATE: begin
               state_d = resolve_page(state_q, page_en);
               if (state_d == state_q && tmr_term) state_d = rotate_page(state_q, page_en);
            end
            ST_OVL: begin
               if (tmr_term) state_d = (ret_q == ST_IDLE) ? ST_IDLE : resolve_page(ret_q, page_en);
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (accept || state_d != state_q || state_q == ST_IDLE) tmr_d = '0;
      else if (tick_ms)                                        tmr_d = tmr_term ? '0 : tmr_q + 1'b1;
      else                                                     tmr_d = tmr_q;
   end

   always_comb begin
      data_d  = '0;
      point_d = '0;
      blank_d = '1;
      page_d  = PAGE_IDLE;
      case (state_q)
         ST_PG_TIME: begin
            data_d  = time_data;
            point_d = time_point;
            blank_d = edit_mask & {DIGITS{blink_off}};
            page_d  = PAGE_TIME;
         end
         ST_PG_DATE: begin
            data_d  = date_data;
            point_d = date_point;
            blank_d = edit_mask & {DIGITS{blink_off}};
            page_d  = PAGE_DATE;
         end
         ST_OVL: begin
            data_d  = ovl_data_q;
            point_d = ovl_point_q;
            blank_d = '0;
            page_d  = PAGE_OVL;
         end
         default: ;
      endcase
   end

   assign ovl_ack   = ack_q;
   assign data      = data_q;
   assign point     = point_q;
   assign dig_blank = blank_q;
   assign page      = page_q;

endmodule

// File: doc/seg_page_sched.md
# seg_page_sched

Display-page scheduler that owns the 24-bit BCD `data` / 6-bit `point` inputs of the 6-digit seven-segment scan driver. It rotates between two live pages (time, date) on a millisecond timebase and pre-empts them with a latched, timed overlay page. It also generates per-digit blink masks for edit mode. It sits between the RTC/setting logic and the scan driver.

## Interface
- `TICK_DIV`, 50_000: clocks per 1 ms tick (50 MHz clk).
- `PAGE_MS`, 3000: ms each live page is shown before rotation.
- `OVL_MS`, 2000: ms an overlay page is held.
- `BLINK_MS`, 500: ms per blink half-period.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `page_en` in 2: bit0 enables the time page, bit1 the date page.
- `time_data` in 24, `time_point` in 6: live time digits / decimal points.
- `date_data` in 24, `date_point` in 6: live date digits / decimal points.
- `ovl_req` in 1: overlay request, level.
- `ovl_data` in 24, `ovl_point` in 6: overlay content, sampled on accept.
- `ovl_ack` out 1: one-cycle pulse on the cycle the overlay is latched.
- `edit_mask` in 6: digits to blink (bit0 = rightmost).
- `data` out 24, `point` out 6: registered, to the scan driver.
- `dig_blank` out 6: registered per-digit blank (1 = dark), for downstream gating.
- `page` out 2: current source. 0 time, 1 date, 2 overlay, 3 idle.

## Operation
- States: IDLE, PG_TIME, PG_DATE, OVL.
- **IDLE**
  - Outputs: `data`=0, `point`=0, `dig_blank`=6'h3F.
  - Leaves for the lowest enabled page the cycle after `page_en`≠0.
- **PG_TIME / PG_DATE**
  - `data`/`point` track the live inputs every cycle.
  - Page timer counts ms ticks 0..PAGE_MS-1. At terminal count, move to the other page if it is enabled, else stay. The timer restarts either way.
  - If the current page's `page_en` bit drops: go to the other enabled page, or IDLE if none. The timer restarts.
- **Overlay accept** (`ovl_req`=1 in any state, including OVL)
  - Latch `ovl_data`/`ovl_point`, pulse `ovl_ack`, enter OVL, restart the hold timer.
  - In IDLE, the return target is IDLE.
  - In a page state, the current page is remembered as the return target.
  - A request held high retriggers every cycle. Requesters drop `ovl_req` on `ovl_ack`.
- **OVL**
  - Shows the latched content. `dig_blank`=0.
  - After OVL_MS ticks, return to the remembered page; its page timer restarts.
  - If the remembered page has since been disabled, the normal disable rule applies on return.
- **Precedence** within one cycle: reset > overlay accept > page disable > rotation.
  - Overlay coinciding with rotation: rotation is suppressed, and the return target is the pre-rotation page.
- **Blink**
  - Free-running phase toggles every BLINK_MS ticks; phase resets to visible.
  - In page states: `dig_blank` = `edit_mask` & {6{phase_off}}.
- Digit values > 9 pass through unmodified.

## Timing
- Reset values:
  - `data`=0, `point`=0, `dig_blank`=6'h3F, `ovl_ack`=0, `page`=3.
  - State IDLE; all counters 0; blink phase visible.
- Tick: prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1.
- Live-input to output latency is 1 clock. State change to output change is 1 clock. `ovl_ack` is registered and coincident with the entry into OVL.
- Rotation occurs on the clock after the PAGE_MS-th tick since page entry. The same applies to overlay expiry after the OVL_MS-th tick.
- Reset mid-overlay discards the latched data and the return target.

## Configuration
- `SEG_BLINK_EN` defined: blink phase counter is present; `edit_mask` behaves as above.
- `SEG_BLINK_EN` undefined:
  - No blink logic; `edit_mask` is ignored.
  - `dig_blank` is 0 in page and OVL states and 6'h3F in IDLE.

## Structure
- Package `seg_pkg`: state enum, page codes (PAGE_TIME=0, PAGE_DATE=1, PAGE_OVL=2, PAGE_IDLE=3), DIGITS=6, width constants.
- Sub-module `seg_ms_tick`: prescaler producing `tick_ms`, plus the blink phase register (inside `SEG_BLINK_EN`).
- Scheduler FSM, timers and output registers live in `seg_page_sched`.

## Test plan
Bench parameters: TICK_DIV=4, PAGE_MS=5, OVL_MS=3, BLINK_MS=2.
- Reset, then `page_en`=2'b11, `time_data`=24'h123456:
  - `page`=0 and `data`=24'h123456 two clocks after `page_en` is set.
  - `page`=1 exactly 5 ticks (20 clocks) after entry.
- `page_en`=2'b01: `page` stays 0 across 3 rotation periods. The timer wraps with no output glitch.
- In PG_DATE, pulse `ovl_req` with `ovl_data`=24'h000042:
  - `ovl_ack` high 1 clock; `page`=2; `data`=24'h000042.
  - Return to `page`=1 after 3 ticks.
- Hold `ovl_req` high for 2 cycles, then pulse again mid-overlay: two `ovl_ack` pulses, then a third. The hold timer restarts each time.
- Assert `ovl_req` on the exact rotation-terminal cycle in PG_TIME: OVL entered, then return to PG_TIME, not PG_DATE.
- `edit_mask`=6'b000011 with `SEG_BLINK_EN`: `dig_blank` alternates 6'b000011 / 0 every 2 ticks.
  - Without the macro: `dig_blank` stays 0.
- Drop `page_en` to 0 during PG_TIME: IDLE next cycle, `dig_blank`=6'h3F. Assert `rst` during OVL: all reset values next clock.
